// File: rtl/hamming_seq_ctrl.sv
// Sequencing controller for a serial Hamming-distance accumulator datapath.
// Optional abort input is enabled by defining HAMMING_CTRL_ABORT_EN.
module hamming_seq_ctrl #(
   parameter int W        = 5,
   parameter int N_CHUNKS = 3200,
   parameter int SUM_W    = 14
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
`ifdef HAMMING_CTRL_ABORT_EN
   input  logic             i_abort,
`endif
   output logic             o_busy,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [W-1:0]     i_in_g,
   input  logic [W-1:0]     i_in_e,
   output logic             o_dp_rst,
   output logic [W-1:0]     o_dp_g,
   output logic [W-1:0]     o_dp_e,
   input  logic [SUM_W-1:0] i_dp_sum,
   output logic             o_done,
   output logic [SUM_W-1:0] o_result,
   output logic             o_result_valid
);

   localparam int CNT_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_CHUNKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [SUM_W-1:0]  r_result;
   logic              r_result_valid;
   logic              w_fire;
   logic              w_last;
   logic              w_abort;

   assign w_fire = (r_state == S_RUN) && i_in_valid;
   assign w_last = w_fire && (r_cnt == LAST_CNT);

   // Abort only acts while an operation is actually in flight.
`ifdef HAMMING_CTRL_ABORT_EN
   assign w_abort = i_abort &&
                    ((r_state == S_CLEAR) || (r_state == S_RUN) || (r_state == S_DRAIN));
`else
   assign w_abort = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_CLEAR;
         S_CLEAR: w_next = S_RUN;
         S_RUN:   if (w_last) w_next = S_DRAIN;
         S_DRAIN: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      if (w_abort) begin
         w_next = S_IDLE;
      end
   end

   always_comb begin
      o_busy     = (r_state != S_IDLE);
      o_in_ready = (r_state == S_RUN);
      o_dp_rst   = (r_state == S_CLEAR);
      o_done     = (r_state == S_DONE);
      o_dp_g     = '0;
      o_dp_e     = '0;
      // Equal (zero) operands on any non-fire cycle keep the running sum frozen.
      if (w_fire) begin
         o_dp_g = i_in_g;
         o_dp_e = i_in_e;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if ((r_state == S_CLEAR) || w_abort) begin
         r_cnt <= '0;
      end else if (w_fire) begin
         r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
   end

   // The registered datapath sum already includes the last chunk during DRAIN.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_result       <= '0;
         r_result_valid <= 1'b0;
      end else if ((r_state == S_IDLE) && i_start) begin
         r_result_valid <= 1'b0;
      end else if ((r_state == S_DRAIN) && !w_abort) begin
         r_result       <= i_dp_sum;
         r_result_valid <= 1'b1;
      end
   end

   assign o_result       = r_result;
   assign o_result_valid = r_result_valid;

endmodule
